// File: rtl/bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bank_rr_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one downstream memory port
//            among NUM_BANKS cache banks. One transaction at a time:
//            IDLE -> ISSUE (Mem_Req held until Mem_Ack) -> RESP (one-cycle
//            Bank_Ack with data). Response bus is all-zero when no Ack.
// Options  : BANK_ARB_TIMEOUT_EN - abandon ISSUE after TIMEOUT cycles without
//            Mem_Ack and answer with all-ones data plus an Arb_Err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bank_rr_arbiter #(
    parameter int NUM_BANKS = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [NUM_BANKS-1:0]        Bank_Req,
    input  logic [NUM_BANKS*ADDR_W-1:0] Bank_Addr,
    output logic [NUM_BANKS-1:0]        Bank_Ack,
    output logic [DATA_W-1:0]           Bank_Data,
    output logic                        Mem_Req,
    output logic [ADDR_W-1:0]           Mem_Addr,
    input  logic                        Mem_Ack,
    input  logic [DATA_W-1:0]           Mem_Data,
    output logic [3:0]                  Grant_Idx,
    output logic                        Arb_Busy,
    output logic                        Arb_Err
);

    localparam int                   c_IDX_W    = $clog2(NUM_BANKS);
    localparam logic [c_IDX_W-1:0]   c_IDX_ONE  = {{(c_IDX_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_BANKS-1:0] c_BANK_LSB = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    // Reject unsupported configurations at elaboration.
    if (NUM_BANKS < 2 || NUM_BANKS > 16 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 || TIMEOUT < 1)
    begin : g_bad_params
        $error("bank_rr_arbiter: NUM_BANKS must be a power of two in 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_winner;
    logic [NUM_BANKS-1:0] r_bank_ack;
    logic [DATA_W-1:0]    r_bank_data;
    logic                 r_mem_req;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_busy;
    logic                 r_err;

    logic [c_IDX_W-1:0]   w_win_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_found;

`ifdef BANK_ARB_TIMEOUT_EN
    localparam int                 c_TMO_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    // Counts completed ISSUE cycles; the TIMEOUT-th one without Mem_Ack expires.
    logic [c_TMO_W-1:0]   r_tmo_cnt;
`endif

    // Scan requests starting at the round-robin pointer; first hit wins.
    always_comb begin
        w_win_idx = r_rr_ptr;
        w_cand    = r_rr_ptr;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_cand = r_rr_ptr + c_IDX_W'(i);
            if (!w_found && Bank_Req[w_cand]) begin
                w_win_idx = w_cand;
                w_found   = 1'b1;
            end
        end
    end

    // Sequencer: grant, hold the downstream request, then pulse the response.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_bank_ack  <= '0;
            r_bank_data <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef BANK_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner   <= w_win_idx;
                        r_mem_addr <= Bank_Addr[w_win_idx*ADDR_W +: ADDR_W];
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
`ifdef BANK_ARB_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    // A real acknowledge always takes precedence over expiry.
                    if (Mem_Ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_addr  <= '0;
                        r_bank_ack  <= c_BANK_LSB << r_winner;
                        r_bank_data <= Mem_Data;
                        r_state     <= S_RESP;
                    end
`ifdef BANK_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_mem_req   <= 1'b0;
                        r_mem_addr  <= '0;
                        r_bank_ack  <= c_BANK_LSB << r_winner;
                        r_bank_data <= '1;
                        r_err       <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt   <= r_tmo_cnt + c_TMO_ONE;
                    end
`endif
                end
                S_RESP: begin
                    r_bank_ack  <= '0;
                    r_bank_data <= '0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rr_ptr    <= r_winner + c_IDX_ONE;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Bank_Ack  = r_bank_ack;
    assign Bank_Data = r_bank_data;
    assign Mem_Req   = r_mem_req;
    assign Mem_Addr  = r_mem_addr;
    assign Grant_Idx = 4'(r_winner);
    assign Arb_Busy  = r_busy;
    assign Arb_Err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_rr_arbiter
// Purpose  : Self-checking bench for bank_rr_arbiter (default build, timeout
//            feature disabled). Directed steps followed by randomized traffic
//            against a distance-based round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_rr_arbiter;

    localparam int NB = 16;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              CLK;
    logic              RSTn;
    logic [NB-1:0]     Bank_Req;
    logic [NB*AW-1:0]  Bank_Addr;
    logic [NB-1:0]     Bank_Ack;
    logic [DW-1:0]     Bank_Data;
    logic              Mem_Req;
    logic [AW-1:0]     Mem_Addr;
    logic              Mem_Ack;
    logic [DW-1:0]     Mem_Data;
    logic [3:0]        Grant_Idx;
    logic              Arb_Busy;
    logic              Arb_Err;

    bank_rr_arbiter #(
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (255)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Bank_Req  (Bank_Req),
        .Bank_Addr (Bank_Addr),
        .Bank_Ack  (Bank_Ack),
        .Bank_Data (Bank_Data),
        .Mem_Req   (Mem_Req),
        .Mem_Addr  (Mem_Addr),
        .Mem_Ack   (Mem_Ack),
        .Mem_Data  (Mem_Data),
        .Grant_Idx (Grant_Idx),
        .Arb_Busy  (Arb_Busy),
        .Arb_Err   (Arb_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pending requests, addresses, priority pointer.
    logic [NB-1:0] req_m;
    logic [AW-1:0] addr_m [NB];
    int            ptr;
    int            last_ack_cyc;
    int            last_grant_dut;
    int            grant_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NB; i++) Bank_Addr[i*AW +: AW] = addr_m[i];
        Bank_Req = req_m;
    endtask

    // Winner = requesting bank with the smallest forward distance from ptr.
    function automatic int model_pick();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NB + 1;
        for (int b = 0; b < NB; b++) begin
            if (req_m[b]) begin
                d = (b - ptr + NB) % NB;
                if (d < bestd) begin
                    bestd = d;
                    best  = b;
                end
            end
        end
        return best;
    endfunction

    // Waits for the grant, checks it, answers after 'delay' stall cycles.
    task automatic serve(input int delay, input logic [DW-1:0] data,
                         input bit keep, input bit drop_early);
        int n;
        int w;
        logic [AW-1:0] a;
        n = 0;
        while (Mem_Req !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("mem_req_rise", 64'(Mem_Req), 64'd1);
        if (Mem_Req !== 1'b1) return;
        w = model_pick();
        if (w < 0) w = 0;
        a = addr_m[w];
        last_grant_dut = int'(Grant_Idx);
        grant_log.push_back(last_grant_dut);
        check("grant_idx", 64'(Grant_Idx), 64'(w));
        check("mem_addr", 64'(Mem_Addr), 64'(a));
        check("busy_issue", 64'({Arb_Busy, Bank_Ack}), 64'({1'b1, 16'h0}));
        if (drop_early) begin
            req_m[w] = 1'b0;
            apply();
        end
        for (int k = 0; k < delay; k++) begin
            @(posedge CLK); #1;
            check("stall_hold", 64'({Mem_Req, Mem_Addr, Bank_Ack, Arb_Busy}),
                  64'({1'b1, a, 16'h0, 1'b1}));
        end
        Mem_Ack  = 1'b1;
        Mem_Data = data;
        @(posedge CLK); #1;
        Mem_Ack  = 1'b0;
        Mem_Data = $urandom;
        last_ack_cyc = cyc;
        check("bank_ack", 64'(Bank_Ack), 64'(16'd1 << w));
        check("bank_data", 64'(Bank_Data), 64'(data));
        check("mem_req_fall", 64'({Mem_Req, Mem_Addr, Arb_Busy, Arb_Err}),
              64'({1'b0, 32'h0, 1'b1, 1'b0}));
        ptr = (w + 1) % NB;
        if (!keep) begin
            req_m[w] = 1'b0;
            apply();
        end
        @(posedge CLK); #1;
        check("idle_gap", 64'({Bank_Ack, Bank_Data, Mem_Req, Arb_Busy}), 64'd0);
        check("grant_hold", 64'(Grant_Idx), 64'(w));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [NB-1:0] once;
        int cnt [NB];

        // Step 1: reset state
        RSTn = 1'b0; Mem_Ack = 1'b0; Mem_Data = '0;
        req_m = '0; ptr = 0;
        for (int i = 0; i < NB; i++) addr_m[i] = $urandom;
        apply();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outs", 64'({Bank_Ack, Bank_Data[15:0], Mem_Req, Grant_Idx, Arb_Busy, Arb_Err}), 64'd0);
        check("reset_data", 64'({Bank_Data, Mem_Addr}), 64'd0);
        @(negedge CLK); RSTn = 1'b1;
        @(posedge CLK); #1;

        // Step 2: Mem_Ack while idle is ignored
        Mem_Ack = 1'b1; Mem_Data = 32'hA5A5_5A5A;
        @(posedge CLK); #1;
        Mem_Ack = 1'b0;
        check("ack_idle_ign", 64'({Bank_Ack, Mem_Req, Arb_Busy, Bank_Data}), 64'd0);
        @(posedge CLK); #1;
        check("ack_idle_ign2", 64'({Bank_Ack, Mem_Req, Arb_Busy, Bank_Data}), 64'd0);

        // Step 3: single request from bank 5, Mem_Ack one cycle after Mem_Req
        c0 = cyc;
        addr_m[5] = 32'h0000_1040; req_m[5] = 1'b1; apply();
        serve(1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("req_to_ack_lat", 64'(last_ack_cyc - c0), 64'd3);

        // Step 4: reset in the middle of ISSUE (asynchronous)
        req_m[9] = 1'b1; apply();
        @(posedge CLK); #1;
        check("pre_rst_issue", 64'({Mem_Req, Arb_Busy}), 64'(2'b11));
        #2 RSTn = 1'b0;
        #1;
        check("async_rst", 64'({Mem_Req, Bank_Ack, Arb_Busy, Grant_Idx}), 64'd0);
        check("async_rst_addr", 64'(Mem_Addr), 64'd0);
        ptr = 0;
        @(negedge CLK); RSTn = 1'b1;

        // Step 5: fairness, all banks requesting and re-requesting
        for (int i = 0; i < NB; i++) if (!req_m[i]) addr_m[i] = $urandom;
        req_m = '1; apply();
        grant_log.delete();
        for (int g = 0; g <= NB; g++) begin
            serve(0, $urandom, 1'b1, 1'b0);
            check("fair_order", 64'(last_grant_dut), 64'(g % NB));
        end
        for (int i = 0; i < NB; i++) cnt[i] = 0;
        for (int g = 0; g < NB && g < grant_log.size(); g++) cnt[grant_log[g] % NB]++;
        for (int i = 0; i < NB; i++) once[i] = (cnt[i] == 1);
        check("fair_unique", 64'(once), 64'(16'hFFFF));
        req_m = '0; apply();
        @(posedge CLK); #1;

        // Step 6: wrap-around priority from pointer 14
        addr_m[13] = 32'h0000_D000; req_m[13] = 1'b1; apply();
        serve(0, 32'h1313_1313, 1'b0, 1'b0);
        addr_m[2]  = 32'h0000_2000; addr_m[15] = 32'h0000_F000;
        req_m[2] = 1'b1; req_m[15] = 1'b1; apply();
        serve(0, 32'h0F0F_0F0F, 1'b0, 1'b0);
        check("wrap_first", 64'(last_grant_dut), 64'd15);
        serve(0, 32'h0202_0202, 1'b0, 1'b0);
        check("wrap_second", 64'(last_grant_dut), 64'd2);

        // Step 7: 40-cycle stall; requester withdraws during ISSUE
        addr_m[7] = 32'h7777_0070; req_m[7] = 1'b1; apply();
        serve(40, 32'hCAFE_F00D, 1'b0, 1'b1);

        // Step 8: randomized traffic
        for (int t = 0; t < 30; t++) begin
            for (int b = 0; b < NB; b++) begin
                if (!req_m[b] && ($urandom_range(0, 3) == 0)) begin
                    addr_m[b] = $urandom;
                    req_m[b]  = 1'b1;
                end
            end
            if (req_m == '0) begin
                c0 = $urandom_range(0, NB - 1);
                addr_m[c0] = $urandom;
                req_m[c0]  = 1'b1;
            end
            apply();
            if ($urandom_range(0, 3) == 0)
                serve($urandom_range(0, 4), $urandom, 1'b1, 1'b0);
            else
                serve($urandom_range(0, 4), $urandom, 1'b0, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
